alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 44 ++++
 rtl/alu.sv | 83 ++++++++
 rtl/alu_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_pkg
// Purpose  : Shared constants and types for the two-requester ALU arbiter:
//            datapath width, ALU opcode encodings, FSM state encodings,
//            flag bit positions and the registered operation bundle.
// Revision : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int FLAG_WIDTH = 3;

  // Flag vector layout: {Overflow, CarryOut, Zero}
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_ZERO  = 0;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_AND  = 3'b000;
  localparam alu_op_t ALU_OR   = 3'b001;
  localparam alu_op_t ALU_XOR  = 3'b100;
  localparam alu_op_t ALU_NOR  = 3'b101;
  localparam alu_op_t ALU_ADD  = 3'b010;
  localparam alu_op_t ALU_SUB  = 3'b110;
  localparam alu_op_t ALU_SLT  = 3'b111;
  localparam alu_op_t ALU_SLTU = 3'b011;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // Operation captured on accept and held for the ALU during EXEC
  typedef struct packed {
    alu_op_t               op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } alu_req_t;

endpackage : alu_arbiter_pkg
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : Purely combinational 32-bit ALU.
//            AND/OR/XOR/NOR, ADD, SUB, SLT (signed) and SLTU (unsigned).
//            SUB/SLT/SLTU all evaluate A-B; their CarryOut is a borrow
//            (set when A < B unsigned). Zero is computed on Result.
// Ports    : i_A, i_B   - operands
//            i_ALUop    - opcode (see alu_arbiter_pkg)
//            o_Result   - result
//            o_flags    - {Overflow, CarryOut, Zero}
// Revision : 1.0 - initial release
// ============================================================================
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] i_A,
  input  logic [DATA_WIDTH-1:0] i_B,
  input  alu_op_t               i_ALUop,
  output logic [DATA_WIDTH-1:0] o_Result,
  output logic [FLAG_WIDTH-1:0] o_flags
);

  localparam int MSB = DATA_WIDTH - 1;

  logic                  w_is_sub;
  logic [DATA_WIDTH-1:0] w_b_eff;
  logic [DATA_WIDTH:0]   w_sum;
  logic                  w_ovf_arith;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_ovf;
  logic                  w_carry;

  assign w_is_sub = (i_ALUop == ALU_SUB) || (i_ALUop == ALU_SLT) || (i_ALUop == ALU_SLTU);
  assign w_b_eff  = w_is_sub ? ~i_B : i_B;

  // One adder serves ADD and A-B (two's complement: A + ~B + 1)
  assign w_sum = {1'b0, i_A} + {1'b0, w_b_eff} + {{DATA_WIDTH{1'b0}}, w_is_sub};

  // Signed overflow: operands of equal sign producing a sum of the other sign
  assign w_ovf_arith = (i_A[MSB] == w_b_eff[MSB]) && (w_sum[MSB] != i_A[MSB]);

  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    w_carry  = 1'b0;
    case (i_ALUop)
      ALU_AND:  w_result = i_A & i_B;
      ALU_OR:   w_result = i_A | i_B;
      ALU_XOR:  w_result = i_A ^ i_B;
      ALU_NOR:  w_result = ~(i_A | i_B);
      ALU_ADD: begin
        w_result = w_sum[MSB:0];
        w_ovf    = w_ovf_arith;
        w_carry  = w_sum[DATA_WIDTH];
      end
      ALU_SUB: begin
        w_result = w_sum[MSB:0];
        w_ovf    = w_ovf_arith;
        w_carry  = ~w_sum[DATA_WIDTH];
      end
      ALU_SLT: begin
        // True sign of A-B is the raw sign corrected by overflow
        w_result = {{(DATA_WIDTH-1){1'b0}}, w_sum[MSB] ^ w_ovf_arith};
        w_ovf    = w_ovf_arith;
        w_carry  = ~w_sum[DATA_WIDTH];
      end
      ALU_SLTU: begin
        w_result = {{(DATA_WIDTH-1){1'b0}}, ~w_sum[DATA_WIDTH]};
        w_ovf    = w_ovf_arith;
        w_carry  = ~w_sum[DATA_WIDTH];
      end
      default: w_result = '0;
    endcase
  end

  assign o_Result              = w_result;
  assign o_flags[FLAG_OVF]     = w_ovf;
  assign o_flags[FLAG_CARRY]   = w_carry;
  assign o_flags[FLAG_ZERO]    = (w_result == '0);

endmodule : alu
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares a single combinational ALU between two requesters with
//            at most one operation in flight (IDLE -> EXEC -> RESP).
//            Operands are registered on accept, evaluated during EXEC and the
//            result/flags are captured into the owner's response registers.
//            Responses hold under unbounded backpressure.
// Config   : ALU_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins a
//            tie; otherwise round-robin with a 1-bit preference pointer.
// Ports    : clk, rst                     - clock, async active-high reset
//            reqN_valid/reqN_ready        - request handshake, N = 0/1
//            reqN_A/reqN_B/reqN_ALUop     - request operands and opcode
//            rspN_valid/rspN_ready        - response handshake
//            rspN_Result/rspN_flags       - registered result, {OVF,CARRY,ZERO}
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_A,
  input  logic [DATA_WIDTH-1:0] req0_B,
  input  logic [2:0]            req0_ALUop,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_A,
  input  logic [DATA_WIDTH-1:0] req1_B,
  input  logic [2:0]            req1_ALUop,

  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_Result,
  output logic [FLAG_WIDTH-1:0] rsp0_flags,

  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_Result,
  output logic [FLAG_WIDTH-1:0] rsp1_flags
);

  state_t                r_state;
  state_t                w_next_state;
  alu_req_t              r_op;
  logic                  r_owner;

  logic                  w_grant_valid;
  logic                  w_grant_id;
  logic                  w_accept;
  logic                  w_owner_rsp_ready;
  alu_req_t              w_req0;
  alu_req_t              w_req1;
  logic [DATA_WIDTH-1:0] w_alu_result;
  logic [FLAG_WIDTH-1:0] w_alu_flags;

  assign w_req0 = '{op: req0_ALUop, a: req0_A, b: req0_B};
  assign w_req1 = '{op: req1_ALUop, a: req1_A, b: req1_B};

  assign w_grant_valid     = req0_valid | req1_valid;
  assign w_accept          = (r_state == ST_IDLE) && w_grant_valid;
  assign w_owner_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;

  // --------------------------------------------------------------------------
  // Grant selection
  // --------------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRIO_EN
  // Requester 0 wins whenever it is valid
  assign w_grant_id = ~req0_valid;
`else
  logic r_ptr;

  always_comb begin
    if (req0_valid && req1_valid) begin
      w_grant_id = r_ptr;
    end else begin
      w_grant_id = req1_valid;
    end
  end

  // After every grant the other requester becomes preferred
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (w_accept) begin
      r_ptr <= ~w_grant_id;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)          w_next_state = ST_EXEC;
      ST_EXEC:                        w_next_state = ST_RESP;
      ST_RESP: if (w_owner_rsp_ready) w_next_state = ST_IDLE;
      default:                        w_next_state = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. Ready is masked by rst so nothing looks accepted while the
  // block is held in reset even though the state register reads IDLE.
  // --------------------------------------------------------------------------
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    if (w_accept && !rst) begin
      req0_ready = ~w_grant_id;
      req1_ready = w_grant_id;
    end
    if (r_state == ST_RESP) begin
      rsp0_valid = ~r_owner;
      rsp1_valid = r_owner;
    end
  end

  // --------------------------------------------------------------------------
  // Operation capture on accept
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= '0;
      r_owner <= 1'b0;
    end else if (w_accept) begin
      r_op    <= w_grant_id ? w_req1 : w_req0;
      r_owner <= w_grant_id;
    end
  end

  alu u_alu (
    .i_A      (r_op.a),
    .i_B      (r_op.b),
    .i_ALUop  (r_op.op),
    .o_Result (w_alu_result),
    .o_flags  (w_alu_flags)
  );

  // --------------------------------------------------------------------------
  // Response registers: only the owner's copy is written at the end of EXEC,
  // the other keeps its previous value.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_Result <= '0;
      rsp0_flags  <= '0;
      rsp1_Result <= '0;
      rsp1_flags  <= '0;
    end else if (r_state == ST_EXEC) begin
      if (r_owner) begin
        rsp1_Result <= w_alu_result;
        rsp1_flags  <= w_alu_flags;
      end else begin
        rsp0_Result <= w_alu_result;
        rsp0_flags  <= w_alu_flags;
      end
    end
  end

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter. Directed vector table plus
//            randomized operations checked against a reference model through
//            a scoreboard queue, and hand-written sequences for arbitration,
//            backpressure and reset during EXEC.
// Config   : honours ALU_ARB_FIXED_PRIO_EN for the arbitration order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_A, req0_B, req1_A, req1_B;
  logic [2:0]  req0_ALUop, req1_ALUop;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_Result, rsp1_Result;
  logic [2:0]  rsp0_flags, rsp1_flags;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_A      (req0_A),
    .req0_B      (req0_B),
    .req0_ALUop  (req0_ALUop),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_A      (req1_A),
    .req1_B      (req1_B),
    .req1_ALUop  (req1_ALUop),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_Result (rsp0_Result),
    .rsp0_flags  (rsp0_flags),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_Result (rsp1_Result),
    .rsp1_flags  (rsp1_flags)
  );

  typedef struct {
    bit          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic [2:0]  flags;
  } vec_t;

  typedef struct {
    bit          id;
    logic [31:0] res;
    logic [2:0]  flags;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_res [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model written from the opcode definitions in wide arithmetic
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       output logic [31:0] r, output logic [2:0] f);
    logic [32:0] s;
    longint      sa, sb, sd;
    longint      c_max, c_min;
    bit          v, c;
    c_max = 64'sh7FFFFFFF;
    c_min = -64'sh80000000;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    v = 1'b0; c = 1'b0; r = '0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b100: r = a ^ b;
      3'b101: r = ~(a | b);
      3'b010: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[31:0];
        c  = s[32];
        sd = sa + sb;
        v  = (sd > c_max) || (sd < c_min);
      end
      default: begin
        r  = a - b;
        c  = (a < b);
        sd = sa - sb;
        v  = (sd > c_max) || (sd < c_min);
        if (op == 3'b111) r = (sa < sb) ? 32'd1 : 32'd0;
        if (op == 3'b011) r = (a < b)   ? 32'd1 : 32'd0;
      end
    endcase
    f = {v, c, (r == 32'd0)};
  endtask

  function automatic logic ready_of(input bit id);
    return id ? req1_ready : req0_ready;
  endfunction
  function automatic logic rsp_valid_of(input bit id);
    return id ? rsp1_valid : rsp0_valid;
  endfunction
  function automatic logic [31:0] rsp_res_of(input bit id);
    return id ? rsp1_Result : rsp0_Result;
  endfunction
  function automatic logic [2:0] rsp_flags_of(input bit id);
    return id ? rsp1_flags : rsp0_flags;
  endfunction

  task automatic set_req(input bit id, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op);
    if (id) begin
      req1_valid = v; req1_A = a; req1_B = b; req1_ALUop = op;
    end else begin
      req0_valid = v; req0_A = a; req0_B = b; req0_ALUop = op;
    end
  endtask

  // Present a request, wait (bounded) for grant, record the expectation and
  // finish on the cycle after the accept edge (FSM in EXEC).
  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [31:0] er, input logic [2:0] ef);
    int waited;
    waited = 0;
    set_req(id, 1'b1, a, b, op);
    #1;
    while (!ready_of(id) && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("grant", ready_of(id), 1);
    sb_q.push_back('{id, er, ef});
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    chk("exec_no_rsp", rsp_valid_of(id), 0);
  endtask

  // Pop the oldest expectation, wait (bounded) for that requester's response,
  // compare it and complete the response handshake.
  task automatic collect();
    exp_t e;
    int   waited;
    if (sb_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected at least 1");
      return;
    end
    e = sb_q.pop_front();
    waited = 0;
    while (!rsp_valid_of(e.id) && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("rsp_valid", rsp_valid_of(e.id), 1);
    chk("result", rsp_res_of(e.id), e.res);
    chk("flags", rsp_flags_of(e.id), e.flags);
    chk("other_rsp_valid", rsp_valid_of(!e.id), 0);
    chk("other_result_held", rsp_res_of(!e.id), last_res[!e.id]);
    last_res[e.id] = e.res;
    if (e.id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    chk("rsp_drop", rsp_valid_of(e.id), 0);
  endtask

  vec_t        vecs [13];
  bit          order [3];
  bit          g;
  int          served0;
  logic [31:0] ra, rb, er;
  logic [2:0]  rop, ef;
  bit          rid;

  initial begin
    vecs[0]  = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 3'b100};
    vecs[1]  = '{1'b1, 32'h00000005, 32'h00000005, 3'b110, 32'h00000000, 3'b001};
    vecs[2]  = '{1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 32'hF000F000, 3'b000};
    vecs[3]  = '{1'b1, 32'h000000F0, 32'h0000000F, 3'b001, 32'h000000FF, 3'b000};
    vecs[4]  = '{1'b0, 32'hAAAA5555, 32'hAAAA5555, 3'b100, 32'h00000000, 3'b001};
    vecs[5]  = '{1'b1, 32'h00000000, 32'h00000000, 3'b101, 32'hFFFFFFFF, 3'b000};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 3'b011};
    vecs[7]  = '{1'b1, 32'h00000000, 32'h00000001, 3'b110, 32'hFFFFFFFF, 3'b010};
    vecs[8]  = '{1'b0, 32'h80000000, 32'h00000001, 3'b110, 32'h7FFFFFFF, 3'b100};
    vecs[9]  = '{1'b1, 32'h80000000, 32'h7FFFFFFF, 3'b111, 32'h00000001, 3'b100};
    vecs[10] = '{1'b0, 32'h00000001, 32'hFFFFFFFF, 3'b011, 32'h00000001, 3'b010};
    vecs[11] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 3'b111, 32'h00000001, 3'b000};
    vecs[12] = '{1'b0, 32'h00000005, 32'h00000005, 3'b011, 32'h00000000, 3'b001};

    // ---------------- reset state (requests valid to probe ready masking)
    rst = 1'b1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set_req(0, 1'b1, 32'h0, 32'h0, 3'b000);
    set_req(1, 1'b1, 32'h0, 32'h0, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_result", rsp0_Result, 0);
    chk("rst_rsp1_result", rsp1_Result, 0);
    chk("rst_rsp0_flags", rsp0_flags, 0);
    chk("rst_rsp1_flags", rsp1_flags, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    last_res[0] = '0; last_res[1] = '0;
    @(posedge clk); #1;

    // ---------------- both valid after reset: arbitration order
`ifdef ALU_ARB_FIXED_PRIO_EN
    order[0] = 1'b0; order[1] = 1'b0; order[2] = 1'b1;
`else
    order[0] = 1'b0; order[1] = 1'b1; order[2] = 1'b0;
`endif
    served0 = 0;
    set_req(0, 1'b1, 32'h00000001, 32'hFFFFFFFF, 3'b011);
    set_req(1, 1'b1, 32'hFFFFFFFF, 32'h00000001, 3'b111);
    #1;
    for (int k = 0; k < 3; k++) begin
      g = order[k];
      chk("arb_grant", ready_of(g), 1);
      chk("arb_other", ready_of(!g), 0);
      if (g) sb_q.push_back('{1'b1, 32'h1, 3'b000});
      else   sb_q.push_back('{1'b0, 32'h1, 3'b010});
      @(posedge clk); #1;
      if (g) begin
        req1_valid = 1'b0;
      end else begin
        served0++;
        if (served0 == 2) req0_valid = 1'b0;
      end
      collect();
    end

    // ---------------- directed vector table
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flags);
      @(posedge clk); #1;
      chk("latency", rsp_valid_of(vecs[i].id), 1);
      collect();
    end

    // ---------------- randomized operations against the model
    for (int i = 0; i < 10; i++) begin
      rid = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? ra : $urandom;
      rop = 3'($urandom_range(0, 7));
      model(ra, rb, rop, er, ef);
      issue(rid, ra, rb, rop, er, ef);
      collect();
    end

    // ---------------- backpressure: hold rsp0_ready low for 10 cycles
    issue(0, 32'd3, 32'd4, 3'b010, 32'd7, 3'b000);
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'h11, 32'h22, 3'b001);
    set_req(1, 1'b1, 32'h33, 32'h44, 3'b001);
    #1;
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", rsp0_valid, 1);
      chk("bp_result", rsp0_Result, 32'd7);
      chk("bp_flags", rsp0_flags, 3'b000);
      chk("bp_req0_ready", req0_ready, 0);
      chk("bp_req1_ready", req1_ready, 0);
      @(posedge clk); #1;
    end
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    #1;
    chk("no_same_cycle_accept", req0_ready, 0);
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    chk("bp_rsp_drop", rsp0_valid, 0);
    chk("idle_after_rsp", req0_ready, 1);
    req0_valid = 1'b0;
    void'(sb_q.pop_front());
    last_res[0] = 32'd7;
    @(posedge clk); #1;

    // ---------------- reset pulsed during EXEC (req0 grant leaves pointer at 1)
    issue(0, 32'd10, 32'd20, 3'b010, 32'd30, 3'b000);
    rst = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("exec_rst_rsp0_valid", rsp0_valid, 0);
    chk("exec_rst_rsp1_valid", rsp1_valid, 0);
    chk("exec_rst_rsp0_result", rsp0_Result, 0);
    chk("exec_rst_rsp1_result", rsp1_Result, 0);
    chk("exec_rst_rsp0_flags", rsp0_flags, 0);
    chk("exec_rst_rsp1_flags", rsp1_flags, 0);
    chk("exec_rst_req1_ready", req1_ready, 0);
    sb_q.delete();
    last_res[0] = '0; last_res[1] = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    req1_valid = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("post_rst_rsp0_valid", rsp0_valid, 0);
      chk("post_rst_rsp1_valid", rsp1_valid, 0);
      @(posedge clk); #1;
    end
    set_req(0, 1'b1, 32'hFFFFFFFF, 32'h0F0F0F0F, 3'b000);
    set_req(1, 1'b1, 32'h00000001, 32'h00000002, 3'b001);
    #1;
    chk("post_rst_ptr_req0", req0_ready, 1);
    chk("post_rst_ptr_req1", req1_ready, 0);
    sb_q.push_back('{1'b0, 32'h0F0F0F0F, 3'b000});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    collect();
    sb_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_alu_arbiter
`default_nettype wire
